// File: rtl/sum_div5.sv
// Sequential restoring divide-by-5 for a 5-operand adder total, one quotient bit per clock.
// Optional round-to-nearest of the quotient: define SUM_DIV5_ROUND_EN.
module sum_div5 #(
  parameter int p_width = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [p_width+2:0]   i_sum,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [p_width-1:0]   o_q,
  output logic [2:0]           o_r,
  output logic                 o_ovf
);

  localparam int unsigned SW = p_width + 3;
  localparam int unsigned CW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [SW-1:0]      dvd, dvd_n;
  logic [SW-1:0]      quo, quo_n;
  logic [2:0]         rem, rem_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [p_width-1:0] q_n;
  logic [2:0]         r_n;
  logic               ovf_n;
  logic               valid_n;
  logic [3:0]         trial;
  logic [SW:0]        qfin;

  // Remainder stays below 5 between steps, so its guard bit only exists in the trial value.
  always_comb begin
    state_n = state;
    dvd_n   = dvd;
    quo_n   = quo;
    rem_n   = rem;
    cnt_n   = cnt;
    q_n     = o_q;
    r_n     = o_r;
    ovf_n   = o_ovf;
    valid_n = 1'b0;
    trial   = {rem, dvd[SW-1]};
    qfin    = {1'b0, quo};
`ifdef SUM_DIV5_ROUND_EN
    if (rem >= 3'd3) qfin = {1'b0, quo} + {{SW{1'b0}}, 1'b1};
`endif
    case (state)
      IDLE: begin
        if (i_start) begin
          dvd_n   = i_sum;
          quo_n   = '0;
          rem_n   = '0;
          cnt_n   = CW'(SW);
          state_n = RUN;
        end
      end
      RUN: begin
        dvd_n = {dvd[SW-2:0], 1'b0};
        if (trial >= 4'd5) begin
          rem_n = trial[2:0] - 3'd5;
          quo_n = {quo[SW-2:0], 1'b1};
        end else begin
          rem_n = trial[2:0];
          quo_n = {quo[SW-2:0], 1'b0};
        end
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = DONE;
      end
      DONE: begin
        if (|qfin[SW:p_width]) begin
          q_n   = '1;
          ovf_n = 1'b1;
        end else begin
          q_n   = qfin[p_width-1:0];
          ovf_n = 1'b0;
        end
        r_n     = rem;
        valid_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      dvd     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      o_q     <= '0;
      o_r     <= '0;
      o_ovf   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_n;
      dvd     <= dvd_n;
      quo     <= quo_n;
      rem     <= rem_n;
      cnt     <= cnt_n;
      o_q     <= q_n;
      o_r     <= r_n;
      o_ovf   <= ovf_n;
      o_valid <= valid_n;
    end
  end

  // Busy also covers the result cycle, when the FSM is already back in IDLE.
  assign o_busy = (state != IDLE) || o_valid;

endmodule

// File: tb/tb_sum_div5.sv
// Scoreboard bench for sum_div5: arithmetic reference model, decoupled result monitor.
module tb_sum_div5;
  localparam int P = 16;
  localparam int LAT = P + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [P+2:0] sum;
  logic         busy, valid, ovf;
  logic [P-1:0] q;
  logic [2:0]   r;

  sum_div5 #(.p_width(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sum(sum),
    .o_busy(busy), .o_valid(valid), .o_q(q), .o_r(r), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [P-1:0] q;
    logic [2:0]   r;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned s, input int acc);
    exp_t e;
    int unsigned qq, rr;
    qq = s / 5;
    rr = s % 5;
`ifdef SUM_DIV5_ROUND_EN
    if (rr >= 3) qq = qq + 1;
`endif
    e.ovf = (qq > 65535);
    e.q   = e.ovf ? 16'hFFFF : qq[15:0];
    e.r   = rr[2:0];
    e.acc = acc;
    return e;
  endfunction

  logic pv = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (valid) begin
        check("valid_width", {31'd0, pv}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("q", {16'd0, q}, {16'd0, e.q});
          check("r", {29'd0, r}, {29'd0, e.r});
          check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          check("latency", cyc - e.acc, LAT);
          check("busy_in_valid", {31'd0, busy}, 32'd1);
        end
      end
      pv = valid;
    end
  end

  // Called at a negedge; waits for IDLE (or the result cycle) then issues one request.
  task automatic do_op(input int unsigned s, input bit push);
    int n = 0;
    while (busy && !valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("busy_timeout", 32'd1, 32'd0);
    sum = s[P+2:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back(model(s, cyc));
    start = 1'b0;
    sum = $urandom;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_q"}, {16'd0, q}, 32'd0);
    check({tag, "_r"}, {29'd0, r}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sum = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("reset_idle");
    end

    do_op(0, 1);
    do_op(327675, 1);
    do_op(12, 1);
    do_op(13, 1);
    do_op(524287, 1);
    drain();

    // A start during a busy run must be dropped.
    do_op(50, 1);
    repeat (4) @(negedge clk);
    sum = 100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (25) @(negedge clk);
    check("ignored_q_hold", {16'd0, q}, 32'd10);
    check("ignored_r_hold", {29'd0, r}, 32'd0);

    // Reset in the middle of a run aborts it silently.
    do_op(1000, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("during_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("after_reset");
    repeat (30) @(negedge clk);
    check_idle_outputs("aborted_quiet");
    do_op(7, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) do_op($urandom_range(524287, 0), 1);
      else            do_op($urandom_range(327675, 0), 1);
    end
    drain();
    repeat (25) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
